// File: rtl/p_ssync_nbit_filt.sv
// WIDTH-bit multi-flop synchroniser with an optional per-bit glitch filter.
// Define SSYNC_EDGE_DET_EN to build the per-bit rise/fall pulse outputs.
module p_ssync_nbit_filt #(
  parameter int                 WIDTH   = 1,
  parameter int                 STAGES  = 3,
  parameter int                 FILTER  = 0,
  parameter logic [WIDTH-1:0]   RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] stable
);

  logic [WIDTH-1:0] stage [STAGES];
  logic [WIDTH-1:0] s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) stage[k] <= RST_VAL;
    end else begin
      stage[0] <= d;
      for (int k = 1; k < STAGES; k++) stage[k] <= stage[k-1];
    end
  end

  assign s = stage[STAGES-1];

  generate
    if (FILTER == 0) begin : g_nofilt
      // The last sync flop doubles as the output register.
      assign q      = s;
      assign stable = {WIDTH{1'b1}};
    end else begin : g_filt
      localparam int            CW   = $clog2(FILTER + 1);
      localparam logic [CW-1:0] CMAX = CW'(FILTER - 1);

      logic [CW-1:0] cnt [WIDTH];

      // Any return of s to q aborts the count, so only runs of FILTER
      // consecutive differing cycles move q.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q <= RST_VAL;
          for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            if (s[i] == q[i]) begin
              cnt[i] <= '0;
            end else if (cnt[i] == CMAX) begin
              q[i]   <= s[i];
              cnt[i] <= '0;
            end else begin
              cnt[i] <= cnt[i] + CW'(1);
            end
          end
        end
      end

      assign stable = ~(s ^ q);
    end
  endgenerate

`ifdef SSYNC_EDGE_DET_EN
  logic [WIDTH-1:0] q_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_prev <= RST_VAL;
    else     q_prev <= q;
  end

  assign rise = q & ~q_prev;
  assign fall = ~q & q_prev;
`else
  assign rise = {WIDTH{1'b0}};
  assign fall = {WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_p_ssync_nbit_filt.sv
// Randomised self-checking bench for p_ssync_nbit_filt: one unfiltered and one
// filtered instance against a history-window reference model.
module tb_p_ssync_nbit_filt;

  localparam int             W  = 4;
  localparam int             SA = 3;
  localparam int             SB = 2;
  localparam int             FB = 3;
  localparam logic [W-1:0]   RV = 4'b1010;

  logic clk = 1'b0;
  logic rst;
  logic [W-1:0] d;
  logic [W-1:0] qA, riseA, fallA, stA;
  logic [W-1:0] qB, riseB, fallB, stB;

  int checks = 0;
  int errors = 0;

  // Reference model: d history (index 0 newest), history of the synced value
  // seen by the filter, and expected q / previous q.
  logic [W-1:0] dh  [16];
  logic [W-1:0] shB [16];
  logic [W-1:0] mqA, mqB, mpA, mpB;

  always #5 clk = ~clk;

  p_ssync_nbit_filt #(.WIDTH(W), .STAGES(SA), .FILTER(0), .RST_VAL(RV)) dutA (
    .clk(clk), .rst(rst), .d(d), .q(qA), .rise(riseA), .fall(fallA), .stable(stA)
  );

  p_ssync_nbit_filt #(.WIDTH(W), .STAGES(SB), .FILTER(FB), .RST_VAL(RV)) dutB (
    .clk(clk), .rst(rst), .d(d), .q(qB), .rise(riseB), .fall(fallB), .stable(stB)
  );

  task automatic checkOutput(input string tag, input logic [W-1:0] got,
                             input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) begin
      dh[i]  = RV;
      shB[i] = RV;
    end
    mqA = RV; mqB = RV; mpA = RV; mpB = RV;
  endtask

  // q of the filtered bit flips once the synced value has differed from it on
  // each of the last FB edges.
  task automatic modelEdge();
    logic [W-1:0] sPre;
    logic         allDiff;
    sPre = dh[SB-1];
    for (int i = 15; i > 0; i--) begin
      dh[i]  = dh[i-1];
      shB[i] = shB[i-1];
    end
    dh[0]  = d;
    shB[0] = sPre;
    mpA = mqA;
    mpB = mqB;
    mqA = dh[SA-1];
    for (int b = 0; b < W; b++) begin
      allDiff = 1'b1;
      for (int k = 0; k < FB; k++)
        if (shB[k][b] == mqB[b]) allDiff = 1'b0;
      if (allDiff) mqB[b] = ~mqB[b];
    end
  endtask

  task automatic checkAll();
    logic [W-1:0] expRiseA, expFallA, expRiseB, expFallB;
`ifdef SSYNC_EDGE_DET_EN
    expRiseA = mqA & ~mpA;  expFallA = ~mqA & mpA;
    expRiseB = mqB & ~mpB;  expFallB = ~mqB & mpB;
`else
    expRiseA = '0; expFallA = '0; expRiseB = '0; expFallB = '0;
`endif
    checkOutput("qA",    qA,    mqA);
    checkOutput("stA",   stA,   {W{1'b1}});
    checkOutput("riseA", riseA, expRiseA);
    checkOutput("fallA", fallA, expFallA);
    checkOutput("qB",    qB,    mqB);
    checkOutput("stB",   stB,   ~(dh[SB-1] ^ mqB));
    checkOutput("riseB", riseB, expRiseB);
    checkOutput("fallB", fallB, expFallB);
  endtask

  task automatic stepCycle(input bit inReset);
    @(posedge clk);
    if (!inReset) modelEdge();
    @(negedge clk);
    checkAll();
  endtask

  task automatic applyStimulus(input logic [W-1:0] val, input int n);
    d = val;
    repeat (n) stepCycle(1'b0);
  endtask

  initial begin
    rst = 1'b1;
    d   = 4'b0101;
    modelReset();
    repeat (3) stepCycle(1'b1);
    checkOutput("rst_qA", qA, RV);
    checkOutput("rst_qB", qB, RV);

    rst = 1'b0;
    repeat (2) stepCycle(1'b0);
    checkOutput("lat2_qA", qA, RV);
    stepCycle(1'b0);
    checkOutput("lat3_qA", qA, 4'b0101);
    applyStimulus(4'b0101, 6);
    checkOutput("settle_qB", qB, 4'b0101);

    // Pulses on bit 0 one short of, then exactly, the filter length.
    applyStimulus(4'b0100, FB - 1);
    applyStimulus(4'b0101, 6);
    checkOutput("reject_qB", qB, 4'b0101);
    applyStimulus(4'b0100, FB);
    applyStimulus(4'b0101, 6);
    // Single-cycle glitch on bit 1 only.
    applyStimulus(4'b0111, 1);
    applyStimulus(4'b0101, 6);
    checkOutput("indep_qB", qB, 4'b0101);

    // Reset while the filter is mid-count.
    applyStimulus(4'b1010, 3);
    rst = 1'b1;
    modelReset();
    repeat (2) stepCycle(1'b1);
    checkOutput("midrst_qB", qB, RV);
    rst = 1'b0;
    applyStimulus(4'b0101, SB + FB - 1);
    checkOutput("midrst_early_qB", qB, RV);
    stepCycle(1'b0);
    checkOutput("midrst_late_qB", qB, 4'b0101);

    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < W; b++)
        if ($urandom_range(3) == 0) d[b] = ~d[b];
      stepCycle(1'b0);
      if (c == 300) begin
        rst = 1'b1;
        modelReset();
        stepCycle(1'b1);
        rst = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
